// File: rtl/traffic_phase_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_ctrl_pkg
// Purpose  : Shared phase codes, time widths and phase helpers for the
//            crossroad controller, lamp driver and display driver.
// Contents : phase_t enum (S_NS_GRN/S_NS_YEL/S_EW_GRN/S_EW_YEL),
//            TIME_W (countdown width), CNT_W (phase counter width),
//            next_phase(), is_green().
// Revision : 1.0 - initial release
// ============================================================================
package traffic_phase_ctrl_pkg;

    localparam int TIME_W = 7;  // countdown value width, holds 1..99
    localparam int CNT_W  = 6;  // phase counter width, holds 1..63

    typedef enum logic [1:0] {
        S_NS_GRN = 2'b00,
        S_NS_YEL = 2'b01,
        S_EW_GRN = 2'b10,
        S_EW_YEL = 2'b11
    } phase_t;

    function automatic phase_t next_phase(input phase_t cur);
        phase_t nxt;
        case (cur)
            S_NS_GRN: nxt = S_NS_YEL;
            S_NS_YEL: nxt = S_EW_GRN;
            S_EW_GRN: nxt = S_EW_YEL;
            default:  nxt = S_NS_GRN;
        endcase
        return nxt;
    endfunction

    function automatic logic is_green(input phase_t cur);
        return (cur == S_NS_GRN) || (cur == S_EW_GRN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_phase_ctrl_sec_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_ctrl_sec_tick_gen
// Purpose  : Divides sys_clk down to a one-cycle tick per second. hold acts
//            as a synchronous clear so the first tick after hold falls is a
//            full second later.
// Ports    : sys_clk   in  system clock
//            sys_rst_n in  asynchronous active-low reset
//            hold      in  1 = clear counter and suppress tick
//            tick      out 1 for the single cycle where sec_cnt==CLK_FREQ-1
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_ctrl_sec_tick_gen #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic hold,
    output logic tick
);

    // A width of at least 1 keeps the counter legal for CLK_FREQ==1.
    localparam int               SEC_W   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [SEC_W-1:0] C_SEC_MAX = SEC_W'(CLK_FREQ - 1);

    logic [SEC_W-1:0] sec_cnt_q;
    logic [SEC_W-1:0] sec_cnt_d;

    always_comb begin
        sec_cnt_d = sec_cnt_q;
        tick      = 1'b0;
        if (hold) begin
            sec_cnt_d = '0;
        end else if (sec_cnt_q == C_SEC_MAX) begin
            sec_cnt_d = '0;
            tick      = 1'b1;
        end else begin
            sec_cnt_d = sec_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sec_cnt_q <= '0;
        end else begin
            sec_cnt_q <= sec_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_ctrl
// Purpose  : Sequences the 4-phase crossroad cycle, produces per-direction
//            countdowns for the segment displays, shortens green on a
//            pedestrian request and freezes everything while hold is high.
// Ports    : sys_clk   in   system clock
//            sys_rst_n in   asynchronous active-low reset
//            ped_req   in   pedestrian request, 1-cycle pulse
//            hold      in   level, 1 = freeze phase and countdown
//            state     out  phase code (00 NSG, 01 NSY, 10 EWG, 11 EWY)
//            ew_time   out  seconds until the EW lamp changes
//            ns_time   out  seconds until the NS lamp changes
//            ped_ack   out  1-cycle pulse when a request shortens green
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_ctrl
    import traffic_phase_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int GREEN_T  = 27,
    parameter int YELLOW_T = 3,
    parameter int PED_MIN  = 5
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              ped_req,
    input  logic              hold,
    output logic [1:0]        state,
    output logic [TIME_W-1:0] ew_time,
    output logic [TIME_W-1:0] ns_time,
    output logic              ped_ack
);

    localparam logic [CNT_W-1:0]  C_GREEN_T   = CNT_W'(GREEN_T);
    localparam logic [CNT_W-1:0]  C_YELLOW_T  = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0]  C_PED_MIN   = CNT_W'(PED_MIN);
    localparam logic [TIME_W-1:0] C_YELLOW_TW = TIME_W'(YELLOW_T);
    localparam logic [TIME_W-1:0] C_EW_RST    = TIME_W'(GREEN_T + YELLOW_T);
    localparam logic [TIME_W-1:0] C_NS_RST    = TIME_W'(GREEN_T);

    logic w_tick;

    phase_t            state_q,     state_d;
    logic [CNT_W-1:0]  phase_cnt_q, phase_cnt_d;
    logic              ped_pend_q,  ped_pend_d;
    logic              ped_ack_q,   ped_ack_d;
    logic [TIME_W-1:0] ew_time_q,   ew_time_d;
    logic [TIME_W-1:0] ns_time_q,   ns_time_d;

    logic [TIME_W-1:0] w_cnt_ext;
    logic [TIME_W-1:0] w_cnt_plus_yel;

    traffic_phase_ctrl_sec_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_sec_tick_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .hold      (hold),
        .tick      (w_tick)
    );

    // Phase sequencing and pedestrian handling. A request arriving on the
    // same cycle as the tick that consumes or clears the pending flag is
    // kept, so it acts on the following tick.
    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        ped_pend_d  = ped_pend_q | ped_req;
        ped_ack_d   = 1'b0;

        if (w_tick) begin
            if (phase_cnt_q == CNT_W'(1)) begin
                state_d = next_phase(state_q);
                if (is_green(state_d)) begin
                    phase_cnt_d = C_GREEN_T;
                end else begin
                    phase_cnt_d = C_YELLOW_T;
                    ped_pend_d  = ped_req;
                end
            end else if (is_green(state_q) && ped_pend_q &&
                         (phase_cnt_q > C_PED_MIN)) begin
                phase_cnt_d = C_PED_MIN;
                ped_pend_d  = ped_req;
                ped_ack_d   = 1'b1;
            end else begin
                phase_cnt_d = phase_cnt_q - 1'b1;
                if (is_green(state_q) && ped_pend_q) begin
                    ped_pend_d = ped_req;
                end
            end
        end
    end

    // Countdowns are derived from the next-state values so they move on the
    // same edge as phase_cnt. During green the other direction still has the
    // following yellow to wait through.
    always_comb begin
        w_cnt_ext      = {1'b0, phase_cnt_d};
        w_cnt_plus_yel = w_cnt_ext + C_YELLOW_TW;
        ew_time_d      = w_cnt_ext;
        ns_time_d      = w_cnt_ext;
        case (state_d)
            S_NS_GRN: ew_time_d = w_cnt_plus_yel;
            S_EW_GRN: ns_time_d = w_cnt_plus_yel;
            default: begin
                ew_time_d = w_cnt_ext;
                ns_time_d = w_cnt_ext;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_NS_GRN;
            phase_cnt_q <= C_GREEN_T;
            ped_pend_q  <= 1'b0;
            ped_ack_q   <= 1'b0;
            ew_time_q   <= C_EW_RST;
            ns_time_q   <= C_NS_RST;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            ped_pend_q  <= ped_pend_d;
            ped_ack_q   <= ped_ack_d;
            ew_time_q   <= ew_time_d;
            ns_time_q   <= ns_time_d;
        end
    end

    assign state   = state_q;
    assign ew_time = ew_time_q;
    assign ns_time = ns_time_q;
    assign ped_ack = ped_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_ctrl
// Purpose  : Scoreboard bench for traffic_phase_ctrl. Stimulus pushes the
//            expected output events (cycle, state, times, ack); a monitor
//            pops one entry each time the DUT outputs change.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_ctrl;

    localparam int CLK_FREQ = 10;
    localparam int GREEN_T  = 6;
    localparam int YELLOW_T = 2;
    localparam int PED_MIN  = 2;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       ped_req   = 1'b0;
    logic       hold      = 1'b0;
    logic [1:0] state;
    logic [6:0] ew_time;
    logic [6:0] ns_time;
    logic       ped_ack;

    traffic_phase_ctrl #(
        .CLK_FREQ (CLK_FREQ),
        .GREEN_T  (GREEN_T),
        .YELLOW_T (YELLOW_T),
        .PED_MIN  (PED_MIN)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .ped_req   (ped_req),
        .hold      (hold),
        .state     (state),
        .ew_time   (ew_time),
        .ns_time   (ns_time),
        .ped_ack   (ped_ack)
    );

    always #5 sys_clk = ~sys_clk;

    // Cycle index since reset release: cycle n is what registers hold after
    // the n-th rising edge.
    int cyc;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    typedef struct {
        int         c;
        logic [1:0] st;
        int         ew;
        int         ns;
        logic       ack;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    // ------------------------------------------------------------------
    // Monitor: an output event is any change of {state, ew, ns, ack}.
    // ------------------------------------------------------------------
    logic [1:0] p_st  = 2'd0;
    logic [6:0] p_ew  = 7'd8;
    logic [6:0] p_ns  = 7'd6;
    logic       p_ack = 1'b0;
    ev_t        mon_e;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            p_st = 2'd0; p_ew = 7'd8; p_ns = 7'd6; p_ack = 1'b0;
        end else if (state != p_st || ew_time != p_ew ||
                     ns_time != p_ns || ped_ack != p_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d got st=%0d ew=%0d ns=%0d ack=%0d",
                         cyc, state, ew_time, ns_time, ped_ack);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.c != cyc || mon_e.st != state || mon_e.ew != int'(ew_time) ||
                    mon_e.ns != int'(ns_time) || mon_e.ack != ped_ack) begin
                    failures++;
                    $display("FAIL event got cyc=%0d st=%0d ew=%0d ns=%0d ack=%0d want cyc=%0d st=%0d ew=%0d ns=%0d ack=%0d",
                             cyc, state, ew_time, ns_time, ped_ack,
                             mon_e.c, mon_e.st, mon_e.ew, mon_e.ns, mon_e.ack);
                end
            end
            p_st = state; p_ew = ew_time; p_ns = ns_time; p_ack = ped_ack;
        end
    end

    // ------------------------------------------------------------------
    // Expected-event helpers (GREEN_T=6, YELLOW_T=2, one second = 10 cycles)
    // ------------------------------------------------------------------
    task automatic push_ev(input int c, input logic [1:0] st, input int ew,
                           input int ns, input logic ack);
        ev_t e;
        e.c = c; e.st = st; e.ew = ew; e.ns = ns; e.ack = ack;
        exp_q.push_back(e);
    endtask

    // Green: own direction counts 6..1, the other 8..3.
    task automatic push_green(input int base, input logic [1:0] st, input bit skip_first);
        for (int i = 0; i < 6; i++) begin
            if (!(skip_first && i == 0)) begin
                if (st == 2'b00) push_ev(base + 10*i, st, 8 - i, 6 - i, 1'b0);
                else             push_ev(base + 10*i, st, 6 - i, 8 - i, 1'b0);
            end
        end
    endtask

    task automatic push_yel(input int base, input logic [1:0] st);
        push_ev(base,      st, 2, 2, 1'b0);
        push_ev(base + 10, st, 1, 1, 1'b0);
    endtask

    task automatic push_cycle(input int base, input bit skip_first);
        push_green(base,       2'b00, skip_first);
        push_yel  (base + 60,  2'b01);
        push_green(base + 80,  2'b10, 1'b0);
        push_yel  (base + 140, 2'b11);
    endtask

    task automatic wait_cyc(input int n);
        do @(negedge sys_clk); while (cyc < n);
    endtask

    task automatic apply_reset();
        sys_rst_n = 1'b0;
        ped_req   = 1'b0;
        hold      = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic pulse_ped(input int c);
        wait_cyc(c);
        ped_req = 1'b1;
        @(negedge sys_clk);
        ped_req = 1'b0;
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (state != 2'd0 || ew_time != 7'd8 || ns_time != 7'd6 || ped_ack != 1'b0) begin
            failures++;
            $display("FAIL %s got st=%0d ew=%0d ns=%0d ack=%0d want st=0 ew=8 ns=6 ack=0",
                     name, state, ew_time, ns_time, ped_ack);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s pending_events got=%0d want=0 next_cyc=%0d",
                     name, exp_q.size(), exp_q[0].c);
        end
        exp_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Free run, late request in EW green, request during NS yellow.
        apply_reset();
        check_reset_vals("reset_state");
        push_cycle(0, 1'b1);
        push_green(160, 2'b00, 1'b0);
        push_yel(220, 2'b01);
        push_ev(240, 2'b10, 6, 8, 1'b0);
        push_ev(250, 2'b10, 2, 4, 1'b1);
        push_ev(251, 2'b10, 2, 4, 1'b0);
        push_ev(260, 2'b10, 1, 3, 1'b0);
        push_yel(270, 2'b11);
        push_ev(290, 2'b00, 8, 6, 1'b0);
        pulse_ped(122);
        pulse_ped(225);
        wait_cyc(295);
        check_drained("free_run_and_ped");

        // Early request in NS green shortens it to PED_MIN.
        apply_reset();
        push_ev(10, 2'b00, 4, 2, 1'b1);
        push_ev(11, 2'b00, 4, 2, 1'b0);
        push_ev(20, 2'b00, 3, 1, 1'b0);
        push_yel(30, 2'b01);
        push_ev(50, 2'b10, 6, 8, 1'b0);
        pulse_ped(5);
        wait_cyc(55);
        check_drained("ped_shorten");

        // Hold for cycles 25..59.
        apply_reset();
        push_ev(10, 2'b00, 7, 5, 1'b0);
        push_ev(20, 2'b00, 6, 4, 1'b0);
        push_ev(70, 2'b00, 5, 3, 1'b0);
        push_ev(80, 2'b00, 4, 2, 1'b0);
        push_ev(90, 2'b00, 3, 1, 1'b0);
        push_yel(100, 2'b01);
        push_ev(120, 2'b10, 6, 8, 1'b0);
        wait_cyc(25);
        hold = 1'b1;
        wait_cyc(60);
        hold = 1'b0;
        wait_cyc(125);
        check_drained("hold");

        // Asynchronous reset during EW yellow.
        apply_reset();
        push_green(0, 2'b00, 1'b1);
        push_yel(60, 2'b01);
        push_green(80, 2'b10, 1'b0);
        push_ev(140, 2'b11, 2, 2, 1'b0);
        wait_cyc(145);
        #1 sys_rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        check_drained("pre_reset");
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        push_green(0, 2'b00, 1'b1);
        push_ev(60, 2'b01, 2, 2, 1'b0);
        wait_cyc(65);
        check_drained("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
